// File: rtl/pprt_row_loader.sv
// Row loader and result capture around the combinational 8-row reduction tree.
// Rows stream in one per beat into a register bank that drives the tree.
// One settle cycle later the tree sum is registered and offered on a
// valid/ready result port. The bank is held until the result is taken.
module pprt_row_loader #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ROWS      = 8,
    parameter int unsigned OUT_WIDTH = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_last,
    output logic [ROWS*WIDTH-1:0]   rows_o,
    input  logic [OUT_WIDTH-1:0]    tree_sum_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_sum,
    output logic [3:0]              out_count
);

    localparam int unsigned IdxW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(ROWS - 1);

    typedef enum logic [1:0] {
        StLoad,
        StSettle,
        StHold
    } state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [ROWS*WIDTH-1:0]  bank_q, bank_d;
    logic [3:0]             count_q, count_d;
    logic [OUT_WIDTH-1:0]   out_sum_q, out_sum_d;
    logic [3:0]             out_count_q, out_count_d;
    logic                   out_valid_q, out_valid_d;
    logic                   accept;

    // Ready only while loading; forced low during reset cycles.
    assign in_ready = (state_q == StLoad) && !rst;
    assign accept   = in_valid && in_ready;

    assign rows_o    = bank_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;

    // Next-state logic: row writes, batch termination, capture and release.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bank_d      = bank_q;
        count_d     = count_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    for (int k = 0; k < int'(ROWS); k++) begin
                        if (idx_q == IdxW'(k)) begin
                            bank_d[k*WIDTH +: WIDTH] = in_data;
                        end
                    end
                    // Unwritten upper rows are already zero, so a short batch
                    // needs no extra fill here.
                    if (in_last || (idx_q == LastIdx)) begin
                        count_d = 4'(idx_q) + 4'd1;
                        state_d = StSettle;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StSettle: begin
                // Tree has had a full cycle to resolve the final bank.
                out_sum_d   = tree_sum_i;
                out_count_d = count_q;
                out_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    bank_d      = '0;
                    idx_d       = '0;
                    state_d     = StLoad;
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // State registers with synchronous reset that discards any partial batch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLoad;
            idx_q       <= '0;
            bank_q      <= '0;
            count_q     <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bank_q      <= bank_d;
            count_q     <= count_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_pprt_row_loader.sv
// Directed bench for pprt_row_loader with a behavioural adder-tree model.
module tb_pprt_row_loader;

    localparam int W  = 16;
    localparam int R  = 8;
    localparam int OW = 19;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic            in_last;
    logic [R*W-1:0]  rows_o;
    logic [OW-1:0]   tree_sum;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_sum;
    logic [3:0]      out_count;

    int checks = 0;
    int errors = 0;

    pprt_row_loader #(
        .WIDTH     (W),
        .ROWS      (R),
        .OUT_WIDTH (OW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .rows_o     (rows_o),
        .tree_sum_i (tree_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference reduction tree: unsigned sum of all rows.
    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < R; k++) begin
            tree_sum = tree_sum + OW'(rows_o[k*W +: W]);
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one row and hold it until accepted (bounded).
    task automatic send_row(input logic [W-1:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check("row_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("valid_seen", out_valid, 1'b1);
    endtask

    // Take the pending result and confirm return to loading.
    task automatic take_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, out_valid, 1'b0);
        check({tag, "_rdy_back"}, in_ready, 1'b1);
    endtask

    logic [R*W-1:0] exp_rows;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum", out_sum, 19'h0);
        check("rst_out_count", out_count, 4'd0);
        check("rst_rows", rows_o, 128'h0);
        check("rst_release_ready", in_ready, 1'b1);

        // Full batch of 0xFFFF with out_ready held high; latency check.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send_row(16'hFFFF, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        in_last  = 1'b0;
        step();                         // last accept edge T
        in_valid = 1'b0;
        check("full_settle_vld", out_valid, 1'b0);
        check("full_settle_rdy", in_ready, 1'b0);
        step();                         // capture edge T+1
        check("full_vld", out_valid, 1'b1);
        check("full_sum", out_sum, 19'h7FFF8);
        check("full_cnt", out_count, 4'd8);
        step();                         // handshake edge
        check("full_vld_drop", out_valid, 1'b0);
        check("full_rdy_back", in_ready, 1'b1);
        out_ready = 1'b0;

        // Rows 1..8.
        for (int i = 0; i < 8; i++) send_row(16'(i + 1), 1'b0);
        wait_valid();
        check("seq_sum", out_sum, 19'h00024);
        check("seq_cnt", out_count, 4'd8);
        check("seq_rows", rows_o, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        take_result("seq");

        // Short batch with in_last on the third beat.
        send_row(16'h1000, 1'b0);
        send_row(16'h2000, 1'b0);
        send_row(16'h3000, 1'b1);
        wait_valid();
        check("short_sum", out_sum, 19'h06000);
        check("short_cnt", out_count, 4'd3);
        check("short_rows", rows_o, {80'h0, 16'h3000, 16'h2000, 16'h1000});
        take_result("short");

        // Backpressure: result and bank held, stray input beats ignored.
        for (int i = 0; i < 3; i++) send_row(16'h0005, 1'b0);
        send_row(16'h0005, 1'b1);
        wait_valid();
        exp_rows = {64'h0, 16'h0005, 16'h0005, 16'h0005, 16'h0005};
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_rdy", in_ready, 1'b0);
            check("bp_vld", out_valid, 1'b1);
            check("bp_sum", out_sum, 19'h00014);
            check("bp_cnt", out_count, 4'd4);
            check("bp_rows", rows_o, exp_rows);
        end
        in_valid = 1'b0;
        take_result("bp");

        // Back-to-back batches prove the bank is cleared between them.
        for (int i = 0; i < 8; i++) send_row(16'h0001, 1'b0);
        wait_valid();
        check("a_sum", out_sum, 19'h00008);
        check("a_cnt", out_count, 4'd8);
        take_result("a");
        send_row(16'h0002, 1'b1);
        wait_valid();
        check("b_sum", out_sum, 19'h00002);
        check("b_cnt", out_count, 4'd1);
        check("b_rows", rows_o, 128'h2);
        take_result("b");

        // Reset after four rows: partial batch discarded.
        for (int i = 0; i < 4; i++) send_row(16'hAAAA, 1'b0);
        rst = 1'b1;
        step();
        check("mid_rst_rdy", in_ready, 1'b0);
        check("mid_rst_vld", out_valid, 1'b0);
        check("mid_rst_rows", rows_o, 128'h0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) send_row(16'h0010, 1'b0);
        wait_valid();
        check("post_rst_sum", out_sum, 19'h00080);
        check("post_rst_cnt", out_count, 4'd8);
        take_result("post_rst");

        // Reset while a result is pending in HOLD.
        send_row(16'h0003, 1'b0);
        send_row(16'h0004, 1'b1);
        wait_valid();
        check("hold_sum", out_sum, 19'h00007);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("hold_rst_vld", out_valid, 1'b0);
        check("hold_rst_cnt", out_count, 4'd0);
        check("hold_rst_rdy", in_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
